// File: rtl/csr_file_if.sv
// csr_file_if: bus bundle between the core/interrupt controller and the machine-mode CSR file
// Signals:
//   reg_read_address_id / id_reg_read_data          ID-stage combinational CSR read
//   reg_write_enable_ex / _address_ex / _data_ex    Zicsr write from EX (data already merged)
//   clint_reg_we / clint_reg_wa / clint_reg_wd      interrupt-controller write (wins on collision)
//   csr_mtvec / csr_mepc / csr_mstatus              stored values back to the interrupt controller
//   interrupt_enable                                mstatus.MIE & mie.MEIE
// Modports: master drives requests (core side), slave is the CSR file.
interface csr_file_if;
  logic [11:0] reg_read_address_id;
  logic [31:0] id_reg_read_data;
  logic        reg_write_enable_ex;
  logic [11:0] reg_write_address_ex;
  logic [31:0] reg_write_data_ex;
  logic        clint_reg_we;
  logic [11:0] clint_reg_wa;
  logic [31:0] clint_reg_wd;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic [31:0] csr_mstatus;
  logic        interrupt_enable;
  modport master (
    output reg_read_address_id, reg_write_enable_ex, reg_write_address_ex, reg_write_data_ex,
           clint_reg_we, clint_reg_wa, clint_reg_wd,
    input  id_reg_read_data, csr_mtvec, csr_mepc, csr_mstatus, interrupt_enable
  );
  modport slave (
    input  reg_read_address_id, reg_write_enable_ex, reg_write_address_ex, reg_write_data_ex,
           clint_reg_we, clint_reg_wa, clint_reg_wd,
    output id_reg_read_data, csr_mtvec, csr_mepc, csr_mstatus, interrupt_enable
  );
endinterface

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file (mstatus, mie, mtvec, mscratch, mepc, mcause, optional mcycle)
// Ports:
//   clk  core clock
//   rst  asynchronous active-high reset
//   bus  csr_file_if.slave: ID read, EX Zicsr write, interrupt-controller write, live CSR outputs
// Parameter RESET_MTVEC: reset value of mtvec (bits [1:0] forced to 0).
// Define CSR_CYCLE_COUNTER_EN to build the 64-bit free-running mcycle/mcycleh counter.
module csr_file #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst,
  csr_file_if.slave bus
);
  localparam int N = 6;
  localparam logic [11:0] A_MTVEC = 12'h305;
  localparam logic [11:0] A_MEPC  = 12'h341;
  localparam logic [11:0] ADDR [N] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342};
  logic        w_c_we, w_e_we;
  logic [11:0] w_c_wa, w_e_wa, w_rd_a;
  logic [31:0] w_c_wd, w_e_wd;
  logic [31:0] r_csr [N];
  logic [N-1:0] w_c_sel, w_e_sel;
  logic [31:0] w_stored;
  logic        w_impl;
  assign w_c_we = bus.clint_reg_we;
  assign w_c_wa = bus.clint_reg_wa;
  assign w_c_wd = bus.clint_reg_wd;
  assign w_e_we = bus.reg_write_enable_ex;
  assign w_e_wa = bus.reg_write_address_ex;
  assign w_e_wd = bus.reg_write_data_ex;
  assign w_rd_a = bus.reg_read_address_id;
  // mtvec is direct-mode only and mepc holds an aligned PC, so their low two bits never store
  function automatic logic [31:0] f_mask(input logic [11:0] a, input logic [31:0] d);
    return (a == A_MTVEC || a == A_MEPC) ? {d[31:2], 2'b00} : d;
  endfunction
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_c_sel[i] = w_c_we && w_c_wa == ADDR[i];
      w_e_sel[i] = w_e_we && w_e_wa == ADDR[i];
    end
  end
  // clint data wins when both writers hit the same register
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int i = 0; i < N; i++) r_csr[i] <= ADDR[i] == A_MTVEC ? {RESET_MTVEC[31:2], 2'b00} : '0;
    else
      for (int i = 0; i < N; i++)
        if (w_c_sel[i] || w_e_sel[i]) r_csr[i] <= f_mask(ADDR[i], w_c_sel[i] ? w_c_wd : w_e_wd);
`ifdef CSR_CYCLE_COUNTER_EN
  localparam logic [11:0] A_MCYCLE  = 12'hB00;
  localparam logic [11:0] A_MCYCLEH = 12'hB80;
  logic [31:0] r_cyc_lo, r_cyc_hi;
  logic        w_lo_c, w_lo_e, w_hi_c, w_hi_e;
  assign w_lo_c = w_c_we && w_c_wa == A_MCYCLE;
  assign w_lo_e = w_e_we && w_e_wa == A_MCYCLE;
  assign w_hi_c = w_c_we && w_c_wa == A_MCYCLEH;
  assign w_hi_e = w_e_we && w_e_wa == A_MCYCLEH;
  // a write to either half suppresses the low-to-high carry for that edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cyc_lo <= '0;
      r_cyc_hi <= '0;
    end else begin
      r_cyc_lo <= w_lo_c ? w_c_wd : w_lo_e ? w_e_wd : r_cyc_lo + 32'd1;
      r_cyc_hi <= w_hi_c ? w_c_wd : w_hi_e ? w_e_wd :
                  r_cyc_hi + {31'd0, !(w_lo_c || w_lo_e) && &r_cyc_lo};
    end
`endif
  always_comb begin
    w_stored = '0;
    w_impl   = 1'b0;
    for (int i = 0; i < N; i++)
      if (w_rd_a == ADDR[i]) begin
        w_stored = r_csr[i];
        w_impl   = 1'b1;
      end
`ifdef CSR_CYCLE_COUNTER_EN
    if (w_rd_a == A_MCYCLE) begin
      w_stored = r_cyc_lo;
      w_impl   = 1'b1;
    end
    if (w_rd_a == A_MCYCLEH) begin
      w_stored = r_cyc_hi;
      w_impl   = 1'b1;
    end
`endif
  end
  // pending writes to the read address are forwarded, clint first; unimplemented reads give 0
  assign bus.id_reg_read_data = !w_impl ? '0 :
                                (w_c_we && w_c_wa == w_rd_a) ? f_mask(w_rd_a, w_c_wd) :
                                (w_e_we && w_e_wa == w_rd_a) ? f_mask(w_rd_a, w_e_wd) : w_stored;
  assign bus.csr_mstatus      = r_csr[0];
  assign bus.csr_mtvec        = r_csr[2];
  assign bus.csr_mepc         = r_csr[4];
  assign bus.interrupt_enable = r_csr[0][3] & r_csr[1][11];
endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: self-checking bench for csr_file with directed scenarios and a randomized model run
module tb_csr_file;
  logic clk = 1'b0;
  logic rst;
  int n_tests = 0;
  int n_fail  = 0;
  always #5 clk = ~clk;
  csr_file_if bus();
  csr_file #(.RESET_MTVEC(32'h0000_1003)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [31:0] m_reg [4096];
  logic [63:0] m_cyc;
  localparam logic [11:0] POOL [10] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                        12'hB00, 12'hB80, 12'h7C0, 12'h001};
  function automatic bit impl(input logic [11:0] a);
`ifdef CSR_CYCLE_COUNTER_EN
    if (a == 12'hB00 || a == 12'hB80) return 1'b1;
`endif
    return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342};
  endfunction
  function automatic logic [31:0] masked(input logic [11:0] a, input logic [31:0] d);
    return (a == 12'h305 || a == 12'h341) ? (d & 32'hFFFF_FFFC) : d;
  endfunction
  function automatic logic [31:0] m_read(input logic [11:0] a);
    if (!impl(a)) return 32'h0;
    if (a == 12'hB00) return m_cyc[31:0];
    if (a == 12'hB80) return m_cyc[63:32];
    return m_reg[a];
  endfunction
  function automatic logic [31:0] m_expect_read(input logic [11:0] a);
    if (!impl(a)) return 32'h0;
    if (bus.clint_reg_we && bus.clint_reg_wa == a) return masked(a, bus.clint_reg_wd);
    if (bus.reg_write_enable_ex && bus.reg_write_address_ex == a) return masked(a, bus.reg_write_data_ex);
    return m_read(a);
  endfunction
  task automatic m_reset();
    foreach (m_reg[i]) m_reg[i] = 32'h0;
    m_reg[12'h305] = 32'h0000_1000;
    m_cyc = 64'h0;
  endtask
  // EX applied first, clint second, so clint is the last writer on a collision
  task automatic m_commit();
    bit lw = 0, hw = 0;
    logic [31:0] ld = 0, hd = 0;
    for (int k = 0; k < 2; k++) begin
      logic we;
      logic [11:0] wa;
      logic [31:0] wd;
      we = k ? bus.clint_reg_we : bus.reg_write_enable_ex;
      wa = k ? bus.clint_reg_wa : bus.reg_write_address_ex;
      wd = k ? bus.clint_reg_wd : bus.reg_write_data_ex;
      if (we && impl(wa)) begin
        if (wa == 12'hB00) begin lw = 1; ld = wd; end
        else if (wa == 12'hB80) begin hw = 1; hd = wd; end
        else m_reg[wa] = masked(wa, wd);
      end
    end
    if (lw || hw) m_cyc = {hw ? hd : m_cyc[63:32], lw ? ld : m_cyc[31:0] + 32'd1};
    else m_cyc = m_cyc + 64'd1;
  endtask
  task automatic tick();
    @(posedge clk);
    if (rst) m_reset(); else m_commit();
    #1;
  endtask
  task automatic drive(input logic ce, input logic [11:0] ca, input logic [31:0] cd,
                       input logic ee, input logic [11:0] ea, input logic [31:0] ed, input logic [11:0] ra);
    bus.clint_reg_we = ce; bus.clint_reg_wa = ca; bus.clint_reg_wd = cd;
    bus.reg_write_enable_ex = ee; bus.reg_write_address_ex = ea; bus.reg_write_data_ex = ed;
    bus.reg_read_address_id = ra;
    #1;
  endtask
  task automatic idle(input logic [11:0] ra);
    drive(0, 12'h0, 32'h0, 0, 12'h0, 32'h0, ra);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    idle(12'h305);
    tick();
    rst = 1'b0;
    #1;
    n_tests++; if (bus.csr_mtvec !== 32'h0000_1000) begin n_fail++; $display("FAIL reset_mtvec: got %h want %h", bus.csr_mtvec, 32'h1000); end
    n_tests++; if (bus.csr_mepc !== 32'h0) begin n_fail++; $display("FAIL reset_mepc: got %h want 0", bus.csr_mepc); end
    n_tests++; if (bus.csr_mstatus !== 32'h0) begin n_fail++; $display("FAIL reset_mstatus: got %h want 0", bus.csr_mstatus); end
    n_tests++; if (bus.interrupt_enable !== 1'b0) begin n_fail++; $display("FAIL reset_ie: got %b want 0", bus.interrupt_enable); end
    n_tests++; if (bus.id_reg_read_data !== 32'h0000_1000) begin n_fail++; $display("FAIL reset_read_mtvec: got %h want %h", bus.id_reg_read_data, 32'h1000); end
  endtask
  task automatic test_interrupt_enable();
    drive(0, 12'h0, 32'h0, 1, 12'h300, 32'h8, 12'h300);
    tick();
    drive(0, 12'h0, 32'h0, 1, 12'h304, 32'h800, 12'h304);
    n_tests++; if (bus.interrupt_enable !== 1'b0) begin n_fail++; $display("FAIL ie_before: got %b want 0", bus.interrupt_enable); end
    n_tests++; if (bus.id_reg_read_data !== 32'h800) begin n_fail++; $display("FAIL ie_fwd_mie: got %h want 800", bus.id_reg_read_data); end
    tick();
    idle(12'h0);
    n_tests++; if (bus.interrupt_enable !== 1'b1) begin n_fail++; $display("FAIL ie_after: got %b want 1", bus.interrupt_enable); end
  endtask
  task automatic test_same_cycle();
    drive(1, 12'h341, 32'h200, 1, 12'h341, 32'h300, 12'h341);
    n_tests++; if (bus.id_reg_read_data !== 32'h200) begin n_fail++; $display("FAIL collide_fwd: got %h want 200", bus.id_reg_read_data); end
    n_tests++; if (bus.csr_mepc !== 32'h0) begin n_fail++; $display("FAIL collide_no_fwd_out: got %h want 0", bus.csr_mepc); end
    tick();
    idle(12'h341);
    n_tests++; if (bus.csr_mepc !== 32'h200) begin n_fail++; $display("FAIL collide_commit: got %h want 200", bus.csr_mepc); end
  endtask
  task automatic test_trap_seq();
    drive(1, 12'h341, 32'h80, 0, 12'h0, 32'h0, 12'h0);
    tick();
    drive(1, 12'h300, 32'h0, 0, 12'h0, 32'h0, 12'h0);
    tick();
    n_tests++; if (bus.interrupt_enable !== 1'b0) begin n_fail++; $display("FAIL trap_ie: got %b want 0", bus.interrupt_enable); end
    drive(1, 12'h342, 32'h8000_000B, 0, 12'h0, 32'h0, 12'h0);
    tick();
    idle(12'h341);
    n_tests++; if (bus.id_reg_read_data !== 32'h80) begin n_fail++; $display("FAIL trap_mepc: got %h want 80", bus.id_reg_read_data); end
    idle(12'h300);
    n_tests++; if (bus.id_reg_read_data !== 32'h0) begin n_fail++; $display("FAIL trap_mstatus: got %h want 0", bus.id_reg_read_data); end
    idle(12'h342);
    n_tests++; if (bus.id_reg_read_data !== 32'h8000_000B) begin n_fail++; $display("FAIL trap_mcause: got %h want 8000000b", bus.id_reg_read_data); end
  endtask
  task automatic test_back_to_back();
    drive(1, 12'h300, 32'h1880, 0, 12'h0, 32'h0, 12'h300);
    tick();
    drive(0, 12'h0, 32'h0, 1, 12'h300, 32'h8, 12'h300);
    n_tests++; if (bus.csr_mstatus !== 32'h1880) begin n_fail++; $display("FAIL b2b_first: got %h want 1880", bus.csr_mstatus); end
    n_tests++; if (bus.id_reg_read_data !== 32'h8) begin n_fail++; $display("FAIL b2b_fwd: got %h want 8", bus.id_reg_read_data); end
    tick();
    idle(12'h0);
    n_tests++; if (bus.csr_mstatus !== 32'h8) begin n_fail++; $display("FAIL b2b_last: got %h want 8", bus.csr_mstatus); end
    n_tests++; if (bus.interrupt_enable !== 1'b1) begin n_fail++; $display("FAIL b2b_ie: got %b want 1", bus.interrupt_enable); end
  endtask
  task automatic test_mask_unimpl();
    drive(0, 12'h0, 32'h0, 1, 12'h305, 32'h0000_2347, 12'h7C0);
    n_tests++; if (bus.id_reg_read_data !== 32'h0) begin n_fail++; $display("FAIL unimpl_read: got %h want 0", bus.id_reg_read_data); end
    tick();
    n_tests++; if (bus.csr_mtvec !== 32'h0000_2344) begin n_fail++; $display("FAIL mtvec_mask: got %h want 2344", bus.csr_mtvec); end
    drive(1, 12'h7C0, $urandom, 1, 12'h7C0, $urandom, 12'h7C0);
    n_tests++; if (bus.id_reg_read_data !== 32'h0) begin n_fail++; $display("FAIL unimpl_fwd: got %h want 0", bus.id_reg_read_data); end
    tick();
    for (int i = 0; i < 6; i++) begin
      idle(POOL[i]);
      n_tests++; if (bus.id_reg_read_data !== m_read(POOL[i])) begin n_fail++; $display("FAIL unimpl_nochange %h: got %h want %h", POOL[i], bus.id_reg_read_data, m_read(POOL[i])); end
    end
  endtask
  task automatic test_counter();
`ifdef CSR_CYCLE_COUNTER_EN
    drive(0, 12'h0, 32'h0, 1, 12'hB00, 32'hFFFF_FFFE, 12'hB00);
    tick();
    idle(12'hB00);
    n_tests++; if (bus.id_reg_read_data !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL cyc_written: got %h want fffffffe", bus.id_reg_read_data); end
    tick();
    tick();
    n_tests++; if (bus.id_reg_read_data !== 32'h0) begin n_fail++; $display("FAIL cyc_wrap_lo: got %h want 0", bus.id_reg_read_data); end
    idle(12'hB80);
    n_tests++; if (bus.id_reg_read_data !== 32'h1) begin n_fail++; $display("FAIL cyc_carry_hi: got %h want 1", bus.id_reg_read_data); end
`else
    drive(0, 12'h0, 32'h0, 1, 12'hB00, 32'h1234_5678, 12'hB00);
    n_tests++; if (bus.id_reg_read_data !== 32'h0) begin n_fail++; $display("FAIL nocyc_fwd: got %h want 0", bus.id_reg_read_data); end
    tick();
    tick();
    idle(12'hB00);
    n_tests++; if (bus.id_reg_read_data !== 32'h0) begin n_fail++; $display("FAIL nocyc_lo: got %h want 0", bus.id_reg_read_data); end
    idle(12'hB80);
    n_tests++; if (bus.id_reg_read_data !== 32'h0) begin n_fail++; $display("FAIL nocyc_hi: got %h want 0", bus.id_reg_read_data); end
`endif
  endtask
  task automatic test_reset_mid_trap();
    drive(1, 12'h341, 32'h44, 0, 12'h0, 32'h0, 12'h0);
    tick();
    drive(1, 12'h342, 32'h8000_0007, 0, 12'h0, 32'h0, 12'h342);
    rst = 1'b1;
    #1;
    n_tests++; if (bus.csr_mepc !== 32'h0) begin n_fail++; $display("FAIL midrst_mepc: got %h want 0", bus.csr_mepc); end
    n_tests++; if (bus.csr_mtvec !== 32'h1000) begin n_fail++; $display("FAIL midrst_mtvec: got %h want 1000", bus.csr_mtvec); end
    idle(12'h342);
    tick();
    rst = 1'b0;
    #1;
    n_tests++; if (bus.id_reg_read_data !== 32'h0) begin n_fail++; $display("FAIL midrst_mcause: got %h want 0", bus.id_reg_read_data); end
  endtask
  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      logic [11:0] ra;
      ra = POOL[$urandom_range(0, 9)];
      drive($urandom_range(0, 2) == 0, POOL[$urandom_range(0, 9)], $urandom,
            $urandom_range(0, 1) == 0, POOL[$urandom_range(0, 9)], $urandom, ra);
      n_tests++; if (bus.id_reg_read_data !== m_expect_read(ra)) begin n_fail++; $display("FAIL rand_read %h: got %h want %h", ra, bus.id_reg_read_data, m_expect_read(ra)); end
      n_tests++;
      if ({bus.csr_mtvec, bus.csr_mepc, bus.csr_mstatus, bus.interrupt_enable} !==
          {m_reg[12'h305], m_reg[12'h341], m_reg[12'h300], m_reg[12'h300][3] & m_reg[12'h304][11]}) begin
        n_fail++;
        $display("FAIL rand_outs: got %h/%h/%h/%b want %h/%h/%h/%b", bus.csr_mtvec, bus.csr_mepc, bus.csr_mstatus,
                 bus.interrupt_enable, m_reg[12'h305], m_reg[12'h341], m_reg[12'h300], m_reg[12'h300][3] & m_reg[12'h304][11]);
      end
      tick();
    end
  endtask
  initial begin
    m_reset();
    test_reset();
    test_interrupt_enable();
    test_same_cycle();
    test_trap_seq();
    test_back_to_back();
    test_mask_unimpl();
    test_counter();
    test_reset_mid_trap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/csr_file.md
# csr_file

Machine-mode control and status register file for the pipelined core, in the ID stage. It is the responder for the interrupt controller's CSR write port (mepc/mcause/mstatus updates on trap entry and mret). It also serves the Zicsr read/write path from ID/EX and supplies the live mtvec, mepc and mstatus values plus the global interrupt-enable back to the interrupt controller. It holds an optional free-running 64-bit cycle counter.

## Interface
- RESET_MTVEC, 32'h0000_0000: reset value of mtvec.
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- reg_read_address_id  in  12  CSR address read by the instruction in ID
- id_reg_read_data  out  32  read data for reg_read_address_id, combinational
- reg_write_enable_ex  in  1  Zicsr write strobe from EX
- reg_write_address_ex  in  12  Zicsr write address
- reg_write_data_ex  in  32  Zicsr write data, already merged for csrrs/csrrc
- clint_reg_we  in  1  interrupt-controller write strobe
- clint_reg_wa  in  12  interrupt-controller write address
- clint_reg_wd  in  32  interrupt-controller write data
- csr_mtvec  out  32  mtvec to interrupt controller
- csr_mepc  out  32  mepc to interrupt controller
- csr_mstatus  out  32  mstatus to interrupt controller
- interrupt_enable  out  1  mstatus[3] (MIE) AND mie[11] (MEIE)

## Operation
- Implemented registers: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342. With the counter compiled in, also mcycle 0xB00 and mcycleh 0xB80.
- Storage: all registers are 32-bit flops. mtvec[1:0] and mepc[1:0] always read 0; written values in those bits are discarded (direct mode, aligned PC).
- Unimplemented address: a read returns 32'h0 and a write is ignored. No exception is raised.
- Write arbitration per cycle:
  - Different addresses: both writes commit.
  - Same address: the clint write commits and the EX write is dropped.
- Read forwarding on id_reg_read_data: if a write to the read address is pending this cycle, return its post-mask data, with clint taking priority over EX. Otherwise return the stored value.
- CLINT-facing outputs csr_mtvec, csr_mepc and csr_mstatus are the stored flop values with no forwarding, so there is no combinational path from clint_reg_* back to them.
- interrupt_enable is computed from the stored mstatus and mie flops only.
- Cycle counter (when enabled):
  - The 64-bit counter increments by 1 every cycle out of reset.
  - It wraps from all-ones to 0.
  - A write to 0xB00 replaces bits [31:0] that cycle and a write to 0xB80 replaces bits [63:32]. The written half holds the written value for that edge with no increment, and incrementing resumes the next cycle.
  - Carry from the low into the high half is suppressed in a cycle where either half is written.

## Timing
- Reset values: mstatus 0, mie 0, mtvec RESET_MTVEC with [1:0] forced 0, mscratch 0, mepc 0, mcause 0, counter 0. Consequently every output is 0 except csr_mtvec, and interrupt_enable is 0.
- Reads are combinational, with zero latency.
- Writes commit on the rising clk edge after the strobe. They are visible on the CLINT-facing outputs and stored reads from the next cycle.
- A strobe held high for N cycles produces N commits; each commit takes that cycle's data.
- Asserting rst mid-trap-sequence (for example between the mepc and mcause writes) clears all registers immediately. The partial trap state is discarded.
- Back-to-back writes to mstatus in consecutive cycles (clint trap entry, then EX csrrw) each commit in order. The last write wins.

## Configuration
- CSR_CYCLE_COUNTER_EN defined: mcycle/mcycleh are implemented as above.
- Not defined: 0xB00 and 0xB80 behave as unimplemented addresses (read 0, writes ignored), and no counter flops are instantiated.

## Test plan
- Reset with RESET_MTVEC=32'h0000_1003 -> csr_mtvec=32'h0000_1000; all other outputs 0; interrupt_enable=0.
- EX writes mstatus=32'h8, then mie=32'h800 -> interrupt_enable goes to 1 one cycle after the second write.
- Same cycle: clint writes 0x341 with 32'h200, and EX writes 0x341 with 32'h300 while reading 0x341 -> id_reg_read_data=32'h200 that cycle; csr_mepc=32'h200 the next cycle.
- Clint sequence mepc=32'h80, mstatus=32'h0, mcause=32'h8000000B on consecutive cycles -> each readable at 0x341/0x300/0x342; interrupt_enable=0 after the mstatus write.
- With the macro defined: EX writes 0xB00=32'hFFFF_FFFE and holds -> after 2 idle cycles mcycle low=0 and mcycleh=1. Without the macro, reading 0xB00 returns 0.
- Read of 0x7C0 -> 0. A write to 0x7C0 changes no register.
